// File: rtl/lvds_data_serializer.sv
// 12-bit word serializer for the LVDS sample stream: training bursts, FIFO-fed data
// words sent LSB-first back to back, and fill words whenever the FIFO runs dry.
module lvds_data_serializer #(
  parameter logic [11:0] TP          = 12'hA5B,
  parameter int unsigned TRAIN_WORDS = 4,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter logic [11:0] FILL_WORD   = 12'h000
) (
  input  logic        CLK_IN,
  input  logic        Test_N,
  input  logic [11:0] din,
  input  logic        din_valid,
  output logic        din_ready,
  input  logic        retrain,
  output logic        serial_data,
  output logic        word_start,
  output logic        training,
  output logic        underflow,
  output logic [15:0] fill_count
);

  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);
  localparam logic [7:0]  TW_L    = 8'(TRAIN_WORDS);

  typedef enum logic {S_TRAIN, S_DATA} state_t;

  state_t        r_state, w_state_next;
  logic [7:0]    r_word_cnt, w_word_cnt_next;
  logic [3:0]    r_bit_cnt;
  logic [10:0]   r_shift;
  logic          r_serial, r_word_start, r_training, r_underflow;
  logic [15:0]   r_fill_count;
  logic          r_retrain_pending;
  logic [11:0]   r_fifo [FIFO_DEPTH];
  logic [AW-1:0] r_rd_ptr, r_wr_ptr;
  logic [AW:0]   r_count, w_count_next;
  logic          r_din_ready;

  logic          w_load, w_empty, w_full, w_push, w_pop;
  logic          w_sel_train, w_sel_fill, w_rp_clear;
  logic [11:0]   w_word;
  logic [7:0]    w_cnt_inc;

  assign w_load    = (r_bit_cnt == 4'd0);
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == DEPTH_L);
  assign w_cnt_inc = r_word_cnt + 8'd1;
  // Occupancy seen by the word selector is the pre-push value, so a word
  // arriving on a load edge into an empty FIFO waits for the next boundary.
  assign w_push       = din_valid && r_din_ready && !w_full;
  assign w_count_next = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);

  always_comb begin
    w_state_next    = r_state;
    w_word_cnt_next = r_word_cnt;
    w_word          = FILL_WORD;
    w_pop           = 1'b0;
    w_sel_train     = 1'b0;
    w_sel_fill      = 1'b0;
    w_rp_clear      = 1'b0;
    if (w_load) begin
      case (r_state)
        S_TRAIN: begin
          w_word      = TP;
          w_sel_train = 1'b1;
          if (w_cnt_inc >= TW_L) begin
            w_state_next    = S_DATA;
            w_word_cnt_next = '0;
          end else begin
            w_word_cnt_next = w_cnt_inc;
          end
        end
        S_DATA: begin
          if (r_retrain_pending) begin
            // This load is already training word 1 of the new burst.
            w_word      = TP;
            w_sel_train = 1'b1;
            w_rp_clear  = 1'b1;
            if (TW_L <= 8'd1) begin
              w_state_next    = S_DATA;
              w_word_cnt_next = '0;
            end else begin
              w_state_next    = S_TRAIN;
              w_word_cnt_next = 8'd1;
            end
          end else if (!w_empty) begin
            w_word = r_fifo[r_rd_ptr];
            w_pop  = 1'b1;
          end else begin
            w_sel_fill = 1'b1;
          end
        end
        default: w_state_next = S_TRAIN;
      endcase
    end
  end

  always_ff @(posedge CLK_IN) begin
    if (Test_N) begin
      r_state           <= S_TRAIN;
      r_word_cnt        <= '0;
      r_bit_cnt         <= '0;
      r_shift           <= '0;
      r_serial          <= 1'b0;
      r_word_start      <= 1'b0;
      r_training        <= 1'b0;
      r_underflow       <= 1'b0;
      r_fill_count      <= '0;
      r_retrain_pending <= 1'b0;
      r_rd_ptr          <= '0;
      r_wr_ptr          <= '0;
      r_count           <= '0;
      r_din_ready       <= 1'b0;
    end else begin
      r_state           <= w_state_next;
      r_word_cnt        <= w_word_cnt_next;
      r_bit_cnt         <= (r_bit_cnt == 4'd11) ? 4'd0 : r_bit_cnt + 4'd1;
      r_retrain_pending <= retrain || (r_retrain_pending && !w_rp_clear);
      if (w_load) begin
        r_serial     <= w_word[0];
        r_shift      <= w_word[11:1];
        r_word_start <= 1'b1;
        r_training   <= w_sel_train;
        r_underflow  <= w_sel_fill;
        if (w_sel_fill && (r_fill_count != '1))
          r_fill_count <= r_fill_count + 16'd1;
      end else begin
        r_serial     <= r_shift[0];
        r_shift      <= {1'b0, r_shift[10:1]};
        r_word_start <= 1'b0;
        r_underflow  <= 1'b0;
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count     <= w_count_next;
      r_din_ready <= (w_count_next != DEPTH_L);
    end
  end

  always_ff @(posedge CLK_IN) begin
    if (!Test_N && w_push) r_fifo[r_wr_ptr] <= din;
  end

  assign din_ready   = r_din_ready;
  assign serial_data = r_serial;
  assign word_start  = r_word_start;
  assign training    = r_training;
  assign underflow   = r_underflow;
  assign fill_count  = r_fill_count;

endmodule

// File: tb/tb_lvds_data_serializer.sv
// Directed bench: a negedge monitor deframes the serial stream into words that
// each scenario task compares against hand-computed sequences.
module tb_lvds_data_serializer;

  logic        CLK_IN = 1'b0;
  logic        Test_N = 1'b1;
  logic [11:0] din = '0;
  logic        din_valid = 1'b0;
  logic        retrain = 1'b0;
  logic        din_ready, serial_data, word_start, training, underflow;
  logic [15:0] fill_count;

  lvds_data_serializer #(
    .TP(12'hA5B), .TRAIN_WORDS(4), .FIFO_DEPTH(4), .FILL_WORD(12'h000)
  ) dut (
    .CLK_IN(CLK_IN), .Test_N(Test_N), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .retrain(retrain), .serial_data(serial_data),
    .word_start(word_start), .training(training), .underflow(underflow),
    .fill_count(fill_count)
  );

  always #5 CLK_IN = ~CLK_IN;

  int n_cmp = 0, n_fail = 0;
  int gap_err = 0, framing_err = 0, uf_err = 0;
  logic [11:0] tp_v = 12'hA5B;

  logic [11:0] q_w[$];
  logic        q_t[$], q_u[$];
  logic [15:0] q_fc[$];
  logic [3:0]  m_n = '0;
  logic [11:0] m_sh;
  logic        m_t, m_u;
  logic [15:0] m_fc;

  // Deframer: rebuilds LSB-first words using word_start as the frame marker.
  always @(negedge CLK_IN) begin
    if (Test_N) m_n = '0;
    else begin
      if (word_start) begin
        if (m_n != 4'd0) framing_err++;
        m_sh = '0; m_sh[0] = serial_data; m_n = 4'd1;
        m_t = training; m_u = underflow; m_fc = fill_count;
      end else if (m_n == 4'd0) gap_err++;
      else begin
        m_sh[m_n] = serial_data; m_n = m_n + 4'd1;
      end
      if (underflow && !word_start) uf_err++;
      if (m_n == 4'd12) begin
        q_w.push_back(m_sh); q_t.push_back(m_t); q_u.push_back(m_u); q_fc.push_back(m_fc);
        m_n = '0;
      end
    end
  end

  task automatic nstep();
    @(negedge CLK_IN); #1;
  endtask

  task automatic clear_q();
    q_w.delete(); q_t.delete(); q_u.delete(); q_fc.delete();
  endtask

  task automatic wait_words(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (q_w.size() >= n) begin ok = 1'b1; break; end
      nstep();
    end
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL wait_words got=%0d exp=%0d words", q_w.size(), n); end
  endtask

  task automatic test_reset();
    Test_N = 1'b1; din_valid = 1'b0; retrain = 1'b0;
    repeat (3) nstep();
    n_cmp++; if (serial_data !== 1'b0) begin n_fail++; $display("FAIL rst_serial got=%b exp=0", serial_data); end
    n_cmp++; if (word_start !== 1'b0) begin n_fail++; $display("FAIL rst_word_start got=%b exp=0", word_start); end
    n_cmp++; if (training !== 1'b0) begin n_fail++; $display("FAIL rst_training got=%b exp=0", training); end
    n_cmp++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL rst_underflow got=%b exp=0", underflow); end
    n_cmp++; if (din_ready !== 1'b0) begin n_fail++; $display("FAIL rst_din_ready got=%b exp=0", din_ready); end
    n_cmp++; if (fill_count !== 16'd0) begin n_fail++; $display("FAIL rst_fill_count got=%0d exp=0", fill_count); end
  endtask

  task automatic test_training();
    logic [3:0] b;
    clear_q();
    Test_N = 1'b0;
    for (int c = 0; c < 48; c++) begin
      nstep();
      b = 4'(c % 12);
      n_cmp++; if (serial_data !== tp_v[b]) begin n_fail++; $display("FAIL trn_bit c=%0d got=%b exp=%b", c, serial_data, tp_v[b]); end
      n_cmp++; if (training !== 1'b1) begin n_fail++; $display("FAIL trn_flag c=%0d got=%b exp=1", c, training); end
      n_cmp++; if (word_start !== (b == 4'd0)) begin n_fail++; $display("FAIL trn_ws c=%0d got=%b exp=%b", c, word_start, b == 4'd0); end
      if (c == 0) begin
        n_cmp++; if (din_ready !== 1'b1) begin n_fail++; $display("FAIL trn_din_ready got=%b exp=1", din_ready); end
      end
    end
    nstep();
    n_cmp++; if (word_start !== 1'b1) begin n_fail++; $display("FAIL fill1_ws got=%b exp=1", word_start); end
    n_cmp++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL fill1_uf got=%b exp=1", underflow); end
    n_cmp++; if (training !== 1'b0) begin n_fail++; $display("FAIL fill1_trn got=%b exp=0", training); end
    n_cmp++; if (serial_data !== 1'b0) begin n_fail++; $display("FAIL fill1_bit got=%b exp=0", serial_data); end
    n_cmp++; if (fill_count !== 16'd1) begin n_fail++; $display("FAIL fill1_count got=%0d exp=1", fill_count); end
  endtask

  task automatic test_stream();
    logic [11:0] ew [9] = '{12'hA5B, 12'hA5B, 12'hA5B, 12'hA5B, 12'h000, 12'h123, 12'h456, 12'h000, 12'h000};
    logic        eu [9] = '{0, 0, 0, 0, 1, 0, 0, 1, 1};
    logic        et [9] = '{1, 1, 1, 1, 0, 0, 0, 0, 0};
    bit ok;
    repeat (3) nstep();
    din = 12'h123; din_valid = 1'b1; nstep();
    din = 12'h456; nstep();
    din_valid = 1'b0;
    wait_words(9, ok);
    if (ok) begin
      for (int i = 0; i < 9; i++) begin
        n_cmp++; if (q_w[i] !== ew[i]) begin n_fail++; $display("FAIL stream_word i=%0d got=%h exp=%h", i, q_w[i], ew[i]); end
        n_cmp++; if (q_u[i] !== eu[i]) begin n_fail++; $display("FAIL stream_uf i=%0d got=%b exp=%b", i, q_u[i], eu[i]); end
        n_cmp++; if (q_t[i] !== et[i]) begin n_fail++; $display("FAIL stream_trn i=%0d got=%b exp=%b", i, q_t[i], et[i]); end
      end
      n_cmp++; if (q_fc[7] !== 16'd2) begin n_fail++; $display("FAIL stream_fc7 got=%0d exp=2", q_fc[7]); end
      n_cmp++; if (q_fc[8] !== 16'd3) begin n_fail++; $display("FAIL stream_fc8 got=%0d exp=3", q_fc[8]); end
    end
  endtask

  task automatic test_boundary_push();
    bit ok;
    din = 12'h7AC; din_valid = 1'b1; nstep();
    din_valid = 1'b0;
    n_cmp++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL bnd_fill_uf got=%b exp=1", underflow); end
    n_cmp++; if (fill_count !== 16'd4) begin n_fail++; $display("FAIL bnd_fill_count got=%0d exp=4", fill_count); end
    wait_words(11, ok);
    if (ok) begin
      n_cmp++; if (q_w[9] !== 12'h000) begin n_fail++; $display("FAIL bnd_w9 got=%h exp=000", q_w[9]); end
      n_cmp++; if (q_w[10] !== 12'h7AC) begin n_fail++; $display("FAIL bnd_w10 got=%h exp=7ac", q_w[10]); end
      n_cmp++; if (q_u[10] !== 1'b0) begin n_fail++; $display("FAIL bnd_w10_uf got=%b exp=0", q_u[10]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] w [5] = '{12'h3C1, 12'h0A5, 12'hF00, 12'h00F, 12'h7E7};
    int k;
    bit acc, ok;
    Test_N = 1'b1; nstep(); nstep();
    clear_q();
    Test_N = 1'b0; din = w[0]; din_valid = 1'b1; k = 0;
    for (int e = 1; e <= 50; e++) begin
      acc = din_valid && din_ready;
      nstep();
      if (acc) begin
        k++;
        if (k < 5) din = w[k]; else din_valid = 1'b0;
      end
      if (e == 5 || e == 48) begin
        n_cmp++; if (k !== 4) begin n_fail++; $display("FAIL b2b_accepts e=%0d got=%0d exp=4", e, k); end
        n_cmp++; if (din_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full_ready e=%0d got=%b exp=0", e, din_ready); end
      end
      if (e == 49) begin
        n_cmp++; if (din_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_rise got=%b exp=1", din_ready); end
      end
      if (e == 50) begin
        n_cmp++; if (k !== 5) begin n_fail++; $display("FAIL b2b_fifth got=%0d exp=5", k); end
      end
    end
    din_valid = 1'b0;
    wait_words(9, ok);
    if (ok) begin
      for (int i = 0; i < 5; i++) begin
        n_cmp++; if (q_w[4+i] !== w[i]) begin n_fail++; $display("FAIL b2b_word i=%0d got=%h exp=%h", i, q_w[4+i], w[i]); end
        n_cmp++; if (q_u[4+i] !== 1'b0) begin n_fail++; $display("FAIL b2b_uf i=%0d got=%b exp=0", i, q_u[4+i]); end
      end
    end
  endtask

  task automatic test_retrain();
    logic [11:0] ew [9] = '{12'h000, 12'h1E3, 12'hA5B, 12'hA5B, 12'hA5B, 12'hA5B, 12'h2D4, 12'h0C5, 12'h000};
    logic        et [9] = '{0, 0, 1, 1, 1, 1, 0, 0, 0};
    bit ok;
    din = 12'h1E3; din_valid = 1'b1; nstep();
    din = 12'h2D4; nstep();
    din = 12'h0C5; nstep();
    din_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin nstep(); if (word_start) break; end
    n_cmp++; if (word_start !== 1'b1) begin n_fail++; $display("FAIL rtr_sync got=%b exp=1", word_start); end
    repeat (5) nstep();
    retrain = 1'b1; nstep();
    retrain = 1'b0;
    wait_words(18, ok);
    if (ok) begin
      for (int i = 0; i < 9; i++) begin
        n_cmp++; if (q_w[9+i] !== ew[i]) begin n_fail++; $display("FAIL rtr_word i=%0d got=%h exp=%h", 9+i, q_w[9+i], ew[i]); end
        n_cmp++; if (q_t[9+i] !== et[i]) begin n_fail++; $display("FAIL rtr_trn i=%0d got=%b exp=%b", 9+i, q_t[9+i], et[i]); end
      end
      n_cmp++; if (q_fc[9] !== 16'd1) begin n_fail++; $display("FAIL rtr_fc got=%0d exp=1", q_fc[9]); end
    end
  endtask

  task automatic test_reset_midword();
    bit ok;
    din = 12'h9C7; din_valid = 1'b1; nstep();
    din = 12'h111; nstep();
    din = 12'h222; nstep();
    din = 12'h333; nstep();
    din_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin nstep(); if (word_start) break; end
    n_cmp++; if (serial_data !== 1'b1) begin n_fail++; $display("FAIL mrst_head_bit0 got=%b exp=1", serial_data); end
    repeat (7) nstep();
    n_cmp++; if (serial_data !== 1'b1) begin n_fail++; $display("FAIL mrst_head_bit7 got=%b exp=1", serial_data); end
    Test_N = 1'b1; nstep();
    n_cmp++; if (serial_data !== 1'b0) begin n_fail++; $display("FAIL mrst_serial got=%b exp=0", serial_data); end
    n_cmp++; if (din_ready !== 1'b0) begin n_fail++; $display("FAIL mrst_din_ready got=%b exp=0", din_ready); end
    n_cmp++; if (fill_count !== 16'd0) begin n_fail++; $display("FAIL mrst_fill_count got=%0d exp=0", fill_count); end
    clear_q();
    Test_N = 1'b0;
    wait_words(5, ok);
    if (ok) begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++; if (q_w[i] !== 12'hA5B || q_t[i] !== 1'b1) begin n_fail++; $display("FAIL mrst_tp i=%0d got=%h/%b exp=a5b/1", i, q_w[i], q_t[i]); end
      end
      n_cmp++; if (q_w[4] !== 12'h000 || q_u[4] !== 1'b1) begin n_fail++; $display("FAIL mrst_lost got=%h/%b exp=000/1", q_w[4], q_u[4]); end
      n_cmp++; if (q_fc[4] !== 16'd1) begin n_fail++; $display("FAIL mrst_fc got=%0d exp=1", q_fc[4]); end
    end
  endtask

  task automatic test_loopback();
    int k, nd, idx;
    bit acc, done;
    clear_q();
    k = 0; din = 12'h001; din_valid = 1'b1;
    for (int i = 0; i < 400 && k < 16; i++) begin
      acc = din_ready;
      nstep();
      if (acc) begin k++; din = 12'(k + 1); end
    end
    din_valid = 1'b0;
    n_cmp++; if (k !== 16) begin n_fail++; $display("FAIL lb_pushed got=%0d exp=16", k); end
    done = 1'b0; nd = 0;
    for (int i = 0; i < 500 && !done; i++) begin
      nd = 0;
      for (int j = 0; j < q_w.size(); j++) if (!q_t[j] && !q_u[j]) nd++;
      if (nd >= 16) done = 1'b1; else nstep();
    end
    n_cmp++; if (nd < 16) begin n_fail++; $display("FAIL lb_count got=%0d exp=16", nd); end
    idx = 0;
    for (int j = 0; j < q_w.size() && idx < 16; j++) begin
      if (!q_t[j] && !q_u[j]) begin
        n_cmp++; if (q_w[j] !== 12'(idx + 1)) begin n_fail++; $display("FAIL lb_word n=%0d got=%h exp=%h", idx, q_w[j], 12'(idx + 1)); end
        idx++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_training();
    test_stream();
    test_boundary_push();
    test_back_to_back();
    test_retrain();
    test_reset_midword();
    test_loopback();
    n_cmp++; if (gap_err !== 0) begin n_fail++; $display("FAIL stream_gaps got=%0d exp=0", gap_err); end
    n_cmp++; if (framing_err !== 0) begin n_fail++; $display("FAIL framing got=%0d exp=0", framing_err); end
    n_cmp++; if (uf_err !== 0) begin n_fail++; $display("FAIL uf_width got=%0d exp=0", uf_err); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
